// File: rtl/dram_req_bridge_pkg.sv
// Shared encodings and helpers for the DRAM request bridge.
package dram_req_bridge_pkg;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StIssue = 2'd1,
      StWait  = 2'd2,
      StDone  = 2'd3
   } dram_state_e;

   // Access size codes carried in ctrl[1:0]
   localparam logic [1:0] DszB = 2'd0;
   localparam logic [1:0] DszH = 2'd1;
   localparam logic [1:0] DszW = 2'd2;
   localparam logic [1:0] DszR = 2'd3;

   localparam int unsigned DramTimeoutDef = 256;

   // Half needs an even address, word needs a 4-byte aligned address
   function automatic logic misaligned(input logic [1:0] a, input logic [1:0] size);
      return ((size == DszH) && a[0]) || ((size == DszW) && (a != 2'b00));
   endfunction

endpackage

// File: rtl/dram_lane_align.sv
// Byte-lane placement for writes and extraction/extension for reads.
module dram_lane_align
   import dram_req_bridge_pkg::*;
(
   input  logic [1:0]  addr,
   input  logic [2:0]  ctrl,
   input  logic [31:0] wdata,
   input  logic [31:0] rdata,
   output logic [3:0]  wstrb,
   output logic [31:0] wdata_al,
   output logic [31:0] rdata_ext,
   output logic        misalign
);

   logic [31:0] rshift;
   logic [15:0] rhalf;

   assign rshift   = rdata >> {addr, 3'b000};
   assign rhalf    = addr[1] ? rdata[31:16] : rdata[15:0];
   assign misalign = misaligned(addr, ctrl[1:0]);

   // Lane selection per access size; reserved size produces nothing
   always_comb begin
      wstrb     = 4'b0000;
      wdata_al  = 32'h0;
      rdata_ext = 32'h0;
      case (ctrl[1:0])
         DszB: begin
            wstrb     = 4'b0001 << addr;
            wdata_al  = {4{wdata[7:0]}};
            rdata_ext = {{24{ctrl[2] & rshift[7]}}, rshift[7:0]};
         end
         DszH: begin
            wstrb     = addr[1] ? 4'b1100 : 4'b0011;
            wdata_al  = {2{wdata[15:0]}};
            rdata_ext = {{16{ctrl[2] & rhalf[15]}}, rhalf};
         end
         DszW: begin
            wstrb     = 4'b1111;
            wdata_al  = wdata;
            rdata_ext = rdata;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/dram_req_bridge.sv
// Converts arbiter-side toggle/pulse requests into single-outstanding memory transactions.
module dram_req_bridge
   import dram_req_bridge_pkg::*;
#(
   parameter int unsigned TIMEOUT = DramTimeoutDef
) (
   input  logic        CLK,
   input  logic        RST_X,
   input  logic [31:0] w_dram_addr,
   input  logic [31:0] w_dram_wdata,
   input  logic        w_dram_we_t,
   input  logic        w_dram_le,
   input  logic [2:0]  w_dram_ctrl,
   output logic [31:0] w_dram_odata,
   output logic        w_dram_busy,
   output logic        o_mem_req,
   output logic        o_mem_we,
   output logic [31:0] o_mem_addr,
   output logic [31:0] o_mem_wdata,
   output logic [3:0]  o_mem_wstrb,
   input  logic        i_mem_ack,
   input  logic [31:0] i_mem_rdata,
   output logic        o_err
);

   // Counter value on the last request cycle before giving up
   localparam logic [7:0] TmoLast = 8'(TIMEOUT - 1);

   dram_state_e state_q, state_d;
   logic [31:0] addr_q, addr_d;
   logic [2:0]  ctrl_q, ctrl_d;
   logic [31:0] wdata_q, wdata_d;
   logic        we_q, we_d;
   logic        pend_q, pend_d;
   logic [7:0]  cnt_q, cnt_d;
   logic [31:0] odata_q, odata_d;
   logic        err_q, err_d;
   logic        we_ref_q;

   logic        wr_ev, rd_ev, bad_in, bad_q;
   logic [3:0]  al_wstrb;
   logic [31:0] al_wdata, al_rdata;
   logic        al_misalign;

   dram_lane_align u_align (
      .addr      (addr_q[1:0]),
      .ctrl      (ctrl_q),
      .wdata     (wdata_q),
      .rdata     (i_mem_rdata),
      .wstrb     (al_wstrb),
      .wdata_al  (al_wdata),
      .rdata_ext (al_rdata),
      .misalign  (al_misalign)
   );

   assign wr_ev  = w_dram_we_t != we_ref_q;
   assign rd_ev  = w_dram_le;
   assign bad_in = misaligned(w_dram_addr[1:0], w_dram_ctrl[1:0]) || (w_dram_ctrl[1:0] == DszR);
   assign bad_q  = al_misalign || (ctrl_q[1:0] == DszR);

   assign w_dram_busy  = (state_q != StIdle) || wr_ev || rd_ev;
   assign w_dram_odata = odata_q;
   assign o_err        = err_q;
   assign o_mem_req    = (state_q == StIssue) || (state_q == StWait);
   assign o_mem_we     = we_q;
   assign o_mem_addr   = {addr_q[31:2], 2'b00};
   assign o_mem_wdata  = al_wdata;
   assign o_mem_wstrb  = we_q ? al_wstrb : 4'b0000;

   // Next-state logic: latch in IDLE, wait for ack or timeout, chain a pending read from DONE
   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      ctrl_d  = ctrl_q;
      wdata_d = wdata_q;
      we_d    = we_q;
      pend_d  = pend_q;
      cnt_d   = cnt_q;
      odata_d = odata_q;
      err_d   = err_q;
      case (state_q)
         StIdle: begin
            if (wr_ev || rd_ev) begin
               addr_d  = w_dram_addr;
               ctrl_d  = w_dram_ctrl;
               wdata_d = w_dram_wdata;
               we_d    = wr_ev;
               pend_d  = wr_ev && rd_ev;
               cnt_d   = 8'd0;
               if (bad_in) begin
                  err_d   = 1'b1;
                  if (!wr_ev) odata_d = 32'h0;
                  state_d = StDone;
               end else begin
                  state_d = StIssue;
               end
            end
         end
         StIssue, StWait: begin
            if (i_mem_ack) begin
               if (!we_q) odata_d = al_rdata;
               state_d = StDone;
            end else if (cnt_q == TmoLast) begin
               err_d   = 1'b1;
               if (!we_q) odata_d = 32'h0;
               state_d = StDone;
            end else begin
               cnt_d   = cnt_q + 8'd1;
               state_d = StWait;
            end
         end
         StDone: begin
            if (pend_q) begin
               // Pending read reuses the latched address and size
               pend_d = 1'b0;
               we_d   = 1'b0;
               cnt_d  = 8'd0;
               if (bad_q) begin
                  err_d   = 1'b1;
                  odata_d = 32'h0;
                  state_d = StDone;
               end else begin
                  state_d = StIssue;
               end
            end else begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // State registers with synchronous active-low reset
   always_ff @(posedge CLK) begin
      if (!RST_X) begin
         state_q  <= StIdle;
         addr_q   <= 32'h0;
         ctrl_q   <= 3'b000;
         wdata_q  <= 32'h0;
         we_q     <= 1'b0;
         pend_q   <= 1'b0;
         cnt_q    <= 8'd0;
         odata_q  <= 32'h0;
         err_q    <= 1'b0;
         we_ref_q <= w_dram_we_t;
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         ctrl_q   <= ctrl_d;
         wdata_q  <= wdata_d;
         we_q     <= we_d;
         pend_q   <= pend_d;
         cnt_q    <= cnt_d;
         odata_q  <= odata_d;
         err_q    <= err_d;
         // Tracks the input even while busy so a dropped toggle never replays
         we_ref_q <= w_dram_we_t;
      end
   end

endmodule

// File: tb/tb_dram_req_bridge.sv
// Directed self-checking bench for dram_req_bridge.
module tb_dram_req_bridge;

   localparam int unsigned Tmo = 16;

   logic        CLK = 1'b0;
   logic        RST_X;
   logic [31:0] w_dram_addr;
   logic [31:0] w_dram_wdata;
   logic        w_dram_we_t;
   logic        w_dram_le;
   logic [2:0]  w_dram_ctrl;
   logic [31:0] w_dram_odata;
   logic        w_dram_busy;
   logic        o_mem_req;
   logic        o_mem_we;
   logic [31:0] o_mem_addr;
   logic [31:0] o_mem_wdata;
   logic [3:0]  o_mem_wstrb;
   logic        i_mem_ack;
   logic [31:0] i_mem_rdata;
   logic        o_err;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 CLK = ~CLK;

   dram_req_bridge #(.TIMEOUT(Tmo)) dut (
      .CLK          (CLK),
      .RST_X        (RST_X),
      .w_dram_addr  (w_dram_addr),
      .w_dram_wdata (w_dram_wdata),
      .w_dram_we_t  (w_dram_we_t),
      .w_dram_le    (w_dram_le),
      .w_dram_ctrl  (w_dram_ctrl),
      .w_dram_odata (w_dram_odata),
      .w_dram_busy  (w_dram_busy),
      .o_mem_req    (o_mem_req),
      .o_mem_we     (o_mem_we),
      .o_mem_addr   (o_mem_addr),
      .o_mem_wdata  (o_mem_wdata),
      .o_mem_wstrb  (o_mem_wstrb),
      .i_mem_ack    (i_mem_ack),
      .i_mem_rdata  (i_mem_rdata),
      .o_err        (o_err)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, got, exp, $time);
      end
   endtask

   // Advance to 1 time unit after the next rising edge
   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic do_reset();
      RST_X = 1'b0;
      tick();
      tick();
      RST_X = 1'b1;
   endtask

   initial begin
      int k;
      int busy_low_at;
      logic req_at_last;
      logic req_after;

      RST_X        = 1'b0;
      w_dram_addr  = 32'h0;
      w_dram_wdata = 32'h0;
      w_dram_we_t  = 1'b0;
      w_dram_le    = 1'b0;
      w_dram_ctrl  = 3'b000;
      i_mem_ack    = 1'b0;
      i_mem_rdata  = 32'h0;
      tick();
      do_reset();
      #1;
      check_eq("rst_req", 32'(o_mem_req), 32'd0);
      check_eq("rst_busy", 32'(w_dram_busy), 32'd0);
      check_eq("rst_addr", o_mem_addr, 32'h0);
      check_eq("rst_wstrb", 32'(o_mem_wstrb), 32'h0);
      check_eq("rst_odata", w_dram_odata, 32'h0);
      check_eq("rst_err", 32'(o_err), 32'd0);

      // Word write, ack two cycles after req rises
      w_dram_addr  = 32'h8000_0104;
      w_dram_wdata = 32'hDEAD_BEEF;
      w_dram_ctrl  = 3'b010;
      w_dram_we_t  = ~w_dram_we_t;
      #1;
      check_eq("ww_busy_T", 32'(w_dram_busy), 32'd1);
      check_eq("ww_req_T", 32'(o_mem_req), 32'd0);
      tick();
      check_eq("ww_req", 32'(o_mem_req), 32'd1);
      check_eq("ww_we", 32'(o_mem_we), 32'd1);
      check_eq("ww_addr", o_mem_addr, 32'h8000_0104);
      check_eq("ww_wstrb", 32'(o_mem_wstrb), 32'hF);
      check_eq("ww_wdata", o_mem_wdata, 32'hDEAD_BEEF);
      tick();
      check_eq("ww_req_hold", 32'(o_mem_req), 32'd1);
      tick();
      check_eq("ww_addr_hold", o_mem_addr, 32'h8000_0104);
      i_mem_ack = 1'b1;
      tick();
      i_mem_ack = 1'b0;
      check_eq("ww_req_done", 32'(o_mem_req), 32'd0);
      check_eq("ww_busy_done", 32'(w_dram_busy), 32'd1);
      tick();
      check_eq("ww_busy_idle", 32'(w_dram_busy), 32'd0);

      // Signed then unsigned byte read at lane 3, ack at first chance
      for (int s = 0; s < 2; s++) begin
         w_dram_addr = 32'h8000_0203;
         w_dram_ctrl = (s == 0) ? 3'b100 : 3'b000;
         w_dram_le   = 1'b1;
         #1;
         check_eq("rb_busy_T", 32'(w_dram_busy), 32'd1);
         tick();
         w_dram_le = 1'b0;
         check_eq("rb_req", 32'(o_mem_req), 32'd1);
         check_eq("rb_we", 32'(o_mem_we), 32'd0);
         check_eq("rb_wstrb", 32'(o_mem_wstrb), 32'h0);
         check_eq("rb_addr", o_mem_addr, 32'h8000_0200);
         i_mem_ack   = 1'b1;
         i_mem_rdata = 32'h80FF_1234;
         tick();
         i_mem_ack = 1'b0;
         check_eq("rb_busy_done", 32'(w_dram_busy), 32'd1);
         check_eq("rb_odata", w_dram_odata, (s == 0) ? 32'hFFFF_FF80 : 32'h0000_0080);
         tick();
         check_eq("rb_busy_T3", 32'(w_dram_busy), 32'd0);
      end

      // Half write to upper half
      w_dram_addr  = 32'h0000_0012;
      w_dram_wdata = 32'h0000_ABCD;
      w_dram_ctrl  = 3'b001;
      w_dram_we_t  = ~w_dram_we_t;
      tick();
      check_eq("hw_wdata", o_mem_wdata, 32'hABCD_ABCD);
      check_eq("hw_wstrb", 32'(o_mem_wstrb), 32'hC);
      i_mem_ack = 1'b1;
      tick();
      i_mem_ack = 1'b0;
      tick();

      // Toggle and pulse together: write then read, busy continuous
      w_dram_addr  = 32'h0000_0040;
      w_dram_wdata = 32'h1122_3344;
      w_dram_ctrl  = 3'b010;
      w_dram_we_t  = ~w_dram_we_t;
      w_dram_le    = 1'b1;
      #1;
      check_eq("both_busy_T", 32'(w_dram_busy), 32'd1);
      tick();
      w_dram_le = 1'b0;
      check_eq("both_wr_we", 32'(o_mem_we), 32'd1);
      check_eq("both_wr_strb", 32'(o_mem_wstrb), 32'hF);
      i_mem_ack = 1'b1;
      tick();
      i_mem_ack = 1'b0;
      check_eq("both_busy_d1", 32'(w_dram_busy), 32'd1);
      tick();
      check_eq("both_rd_req", 32'(o_mem_req), 32'd1);
      check_eq("both_rd_we", 32'(o_mem_we), 32'd0);
      check_eq("both_rd_addr", o_mem_addr, 32'h0000_0040);
      check_eq("both_rd_strb", 32'(o_mem_wstrb), 32'h0);
      i_mem_ack   = 1'b1;
      i_mem_rdata = 32'hCAFE_F00D;
      tick();
      i_mem_ack = 1'b0;
      check_eq("both_busy_d2", 32'(w_dram_busy), 32'd1);
      check_eq("both_odata", w_dram_odata, 32'hCAFE_F00D);
      tick();
      check_eq("both_idle", 32'(w_dram_busy), 32'd0);

      // Misaligned word read: no request, error, odata cleared
      w_dram_addr = 32'h0000_0101;
      w_dram_ctrl = 3'b010;
      w_dram_le   = 1'b1;
      tick();
      w_dram_le = 1'b0;
      check_eq("mis_req", 32'(o_mem_req), 32'd0);
      check_eq("mis_err", 32'(o_err), 32'd1);
      check_eq("mis_odata", w_dram_odata, 32'h0);
      check_eq("mis_busy", 32'(w_dram_busy), 32'd1);
      tick();
      check_eq("mis_idle", 32'(w_dram_busy), 32'd0);

      // Reset clears the sticky error, then a read that never gets an ack
      do_reset();
      #1;
      check_eq("tmo_err0", 32'(o_err), 32'd0);
      w_dram_addr = 32'h0000_0200;
      w_dram_ctrl = 3'b010;
      w_dram_le   = 1'b1;
      busy_low_at = -1;
      req_at_last = 1'b0;
      req_after   = 1'b1;
      for (k = 1; k <= 40; k++) begin
         tick();
         w_dram_le = 1'b0;
         if (k == Tmo) req_at_last = o_mem_req;
         if (k == Tmo + 1) req_after = o_mem_req;
         if (!w_dram_busy) begin
            busy_low_at = k;
            break;
         end
      end
      check_eq("tmo_busy_low", 32'(busy_low_at), 32'(Tmo + 2));
      check_eq("tmo_req_last", 32'(req_at_last), 32'd1);
      check_eq("tmo_req_drop", 32'(req_after), 32'd0);
      check_eq("tmo_err", 32'(o_err), 32'd1);

      // Reset while waiting for ack; late ack ignored, no write replay
      do_reset();
      w_dram_addr  = 32'h0000_0300;
      w_dram_wdata = 32'h5555_AAAA;
      w_dram_ctrl  = 3'b010;
      w_dram_we_t  = ~w_dram_we_t;
      tick();
      tick();
      check_eq("rw_req_wait", 32'(o_mem_req), 32'd1);
      RST_X = 1'b0;
      tick();
      check_eq("rw_req_rst", 32'(o_mem_req), 32'd0);
      RST_X = 1'b1;
      tick();
      check_eq("rw_no_replay", 32'(w_dram_busy), 32'd0);
      i_mem_ack   = 1'b1;
      i_mem_rdata = 32'h1234_5678;
      tick();
      i_mem_ack = 1'b0;
      check_eq("rw_late_odata", w_dram_odata, 32'h0);
      check_eq("rw_late_req", 32'(o_mem_req), 32'd0);
      tick();
      check_eq("rw_late_busy", 32'(w_dram_busy), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   // Global watchdog so the bench always terminates
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
